// File: rtl/gru_param_loader_pkg.sv
// Shared types and constants for the GRU parameter loader.
package gru_param_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;

  localparam int W_FRAME_LEN = 8;
  localparam int H_FRAME_LEN = 4;
  localparam int IDX_W       = 4;
  localparam logic [15:0] ONE = 16'h4000;  // 1.0 in Q2.14
endpackage

// File: rtl/gru_param_loader.sv
// Serial loader for GRU weight rows and hidden vector; fires the output stage
// once a hidden frame lands on top of a loaded weight set.
module gru_param_loader
  import gru_param_loader_pkg::*;
#(
  parameter int WORD_W   = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_sel,
  input  logic              result_valid,
  output logic [WORD_W-1:0] w11, w12, w13, w14,
  output logic [WORD_W-1:0] w21, w22, w23, w24,
  output logic [WORD_W-1:0] h1, h2, h3, h4,
  output logic              en,
  output logic              busy,
  output logic              err
);
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic                 frame_w;
  logic                 w_loaded;
  logic [CNT_W-1:0]     wait_cnt;
  logic [WORD_W-1:0]    stage [W_FRAME_LEN];

  logic xfer, last_w, last_h;

  assign s_ready = (state == IDLE) || (state == LOAD);
  assign busy    = (state != IDLE);
  assign xfer    = s_valid && s_ready;
  assign last_w  = frame_w  && (idx == IDX_W'(W_FRAME_LEN - 1));
  assign last_h  = !frame_w && (idx == IDX_W'(H_FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      frame_w  <= 1'b0;
      w_loaded <= 1'b0;
      wait_cnt <= '0;
      en       <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < W_FRAME_LEN; i++) stage[i] <= '0;
      {w11, w12, w13, w14, w21, w22, w23, w24} <= '0;
      {h1, h2, h3, h4} <= '0;
    end else begin
      en <= 1'b0;
      case (state)
        IDLE: if (xfer) begin
          frame_w  <= s_sel;
          stage[0] <= s_data;
          idx      <= IDX_W'(1);
          state    <= LOAD;
        end
        LOAD: if (xfer) begin
          stage[idx[IDX_W-2:0]] <= s_data;
          idx <= idx + 1'b1;
          // Final word bypasses staging so the whole set updates on this edge.
          if (last_w) begin
            {w11, w12, w13, w14} <= {stage[0], stage[1], stage[2], stage[3]};
            {w21, w22, w23, w24} <= {stage[4], stage[5], stage[6], s_data};
            w_loaded <= 1'b1;
            idx      <= '0;
            state    <= IDLE;
          end else if (last_h) begin
            idx <= '0;
            if (w_loaded) begin
              {h1, h2, h3, h4} <= {stage[0], stage[1], stage[2], s_data};
              en    <= 1'b1;
              state <= FIRE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        FIRE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (result_valid) begin
            state <= IDLE;
          end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gru_param_loader.sv
// Directed bench for gru_param_loader: frame loading, firing, timeout and reset.
module tb_gru_param_loader;
  import gru_param_loader_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        s_valid = 1'b0, s_sel = 1'b0, result_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, en, busy, err;
  logic [15:0] w11, w12, w13, w14, w21, w22, w23, w24, h1, h2, h3, h4;
  logic [127:0] w_all;
  logic [63:0]  h_all;
  int total = 0, bad = 0, en_total = 0;

  gru_param_loader #(.WORD_W(16), .WAIT_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sel(s_sel), .result_valid(result_valid),
    .w11(w11), .w12(w12), .w13(w13), .w14(w14),
    .w21(w21), .w22(w22), .w23(w23), .w24(w24),
    .h1(h1), .h2(h2), .h3(h3), .h4(h4),
    .en(en), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  assign w_all = {w11, w12, w13, w14, w21, w22, w23, w24};
  assign h_all = {h1, h2, h3, h4};
  always @(negedge clk) if (en === 1'b1) en_total++;

  task automatic xfer(input logic [15:0] d, input logic sel);
    s_valid = 1'b1; s_data = d; s_sel = sel;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; result_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (w_all !== '0) begin bad++; $display("FAIL reset_w: got %h want 0", w_all); end
    total++; if (h_all !== '0) begin bad++; $display("FAIL reset_h: got %h want 0", h_all); end
    total++; if ({busy, en, err} !== 3'b000) begin bad++; $display("FAIL reset_flags: busy/en/err got %b want 000", {busy, en, err}); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_weight();
    int base = en_total;
    for (int i = 1; i <= 8; i++) begin
      xfer(16'(i), 1'b1);
      if (i == 7) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL weight_busy_mid: got %b want 1", busy); end
      end
    end
    s_valid = 1'b0;
    total++; if (w_all !== {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}) begin bad++; $display("FAIL weight_values: got %h", w_all); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL weight_busy_end: got %b want 0", busy); end
    @(posedge clk); #1;
    total++; if (en_total != base) begin bad++; $display("FAIL weight_no_en: got %0d pulses want 0", en_total - base); end
    total++; if (h_all !== '0 || err !== 1'b0) begin bad++; $display("FAIL weight_side: h=%h err=%b want 0/0", h_all, err); end
  endtask

  task automatic test_hidden_fire();
    int base = en_total;
    xfer(ONE, 1'b0); xfer(16'hC000, 1'b0); xfer(16'h2000, 1'b0); xfer(16'h0000, 1'b0);
    s_valid = 1'b0;
    total++; if (h_all !== {ONE, 16'hC000, 16'h2000, 16'h0000}) begin bad++; $display("FAIL hidden_values: got %h", h_all); end
    total++; if (en !== 1'b1) begin bad++; $display("FAIL hidden_en_latency: got %b want 1", en); end
    total++; if (s_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL hidden_fire_state: ready=%b busy=%b want 0/1", s_ready, busy); end
    @(posedge clk); #1;
    total++; if (en !== 1'b0) begin bad++; $display("FAIL hidden_en_width: got %b want 0", en); end
    // words offered while waiting must be refused
    s_valid = 1'b1; s_data = 16'hFFFF; s_sel = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++; if (s_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wait_ready: ready=%b busy=%b want 0/1", s_ready, busy); end
    s_valid = 1'b0; result_valid = 1'b1;
    @(posedge clk); #1 result_valid = 1'b0;
    total++; if (busy !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL wait_exit: busy=%b ready=%b want 0/1", busy, s_ready); end
    total++; if (en_total - base != 1) begin bad++; $display("FAIL hidden_en_count: got %0d want 1", en_total - base); end
    total++; if (h_all !== {ONE, 16'hC000, 16'h2000, 16'h0000} || w_all !== {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8})
      begin bad++; $display("FAIL wait_hold: h=%h w=%h", h_all, w_all); end
  endtask

  task automatic test_stall_toggle();
    int base = en_total;
    result_valid = 1'b1;  // must be ignored outside WAIT
    for (int i = 0; i < 8; i++) begin
      xfer(16'hA000 + 16'(i), (i == 0) ? 1'b1 : 1'b0);
      s_valid = 1'b0; s_sel = ~s_sel;
      if (i < 7) begin
        repeat ((i == 2) ? 3 : 1) @(posedge clk); #1;
      end
      if (i == 3) begin
        total++; if (s_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL stall_type: ready=%b busy=%b want 1/1", s_ready, busy); end
        total++; if (w_all !== {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}) begin bad++; $display("FAIL stall_partial: got %h", w_all); end
      end
    end
    result_valid = 1'b0;
    total++; if (w_all !== {16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006, 16'hA007})
      begin bad++; $display("FAIL stall_values: got %h", w_all); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || err !== 1'b0 || en_total != base) begin bad++; $display("FAIL stall_end: busy=%b err=%b en=%0d want 0/0/0", busy, err, en_total - base); end
  endtask

  task automatic test_timeout();
    int n = 0;
    xfer(16'h0001, 1'b0); xfer(16'h0002, 1'b0); xfer(16'h0003, 1'b0); xfer(16'h0004, 1'b0);
    s_valid = 1'b0;
    total++; if (en !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL timeout_fire: en=%b err=%b want 1/0", en, err); end
    while (busy === 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (n != 256) begin bad++; $display("FAIL timeout_cycles: got %0d want 256", n); end
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_err: err=%b busy=%b want 1/0", err, busy); end
    xfer(16'h0005, 1'b0); xfer(16'h0006, 1'b0); xfer(16'h0007, 1'b0); xfer(16'h0008, 1'b0);
    s_valid = 1'b0;
    total++; if (en !== 1'b1 || h_all !== {16'd5, 16'd6, 16'd7, 16'd8}) begin bad++; $display("FAIL timeout_next: en=%b h=%h", en, h_all); end
    @(posedge clk); #1 result_valid = 1'b1;
    @(posedge clk); #1 result_valid = 1'b0;
    total++; if (busy !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: busy=%b err=%b want 0/1", busy, err); end
  endtask

  task automatic test_hidden_no_weight();
    int base;
    do_reset();
    base = en_total;
    xfer(ONE, 1'b0); xfer(16'hC000, 1'b0); xfer(16'h2000, 1'b0); xfer(16'h0000, 1'b0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL noweight_err: got %b want 1", err); end
    total++; if (h_all !== '0 || en_total != base) begin bad++; $display("FAIL noweight_h: h=%h en=%0d want 0/0", h_all, en_total - base); end
    total++; if (busy !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL noweight_idle: busy=%b ready=%b", busy, s_ready); end
  endtask

  task automatic test_mid_reset();
    int base;
    for (int i = 0; i < 8; i++) xfer(16'h0011 + 16'(i), 1'b1);
    for (int i = 0; i < 5; i++) xfer(16'h0021 + 16'(i), 1'b1);
    total++; if (w_all !== {16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17, 16'h18}) begin bad++; $display("FAIL midrst_partial: got %h", w_all); end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (w_all !== '0 || h_all !== '0) begin bad++; $display("FAIL midrst_async: w=%h h=%h want 0", w_all, h_all); end
    total++; if ({busy, err, en} !== 3'b000) begin bad++; $display("FAIL midrst_flags: busy/err/en got %b want 000", {busy, err, en}); end
    @(posedge clk); #1 rst_n = 1'b1;
    base = en_total;
    xfer(16'h0001, 1'b0); xfer(16'h0002, 1'b0); xfer(16'h0003, 1'b0); xfer(16'h0004, 1'b0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (err !== 1'b1 || h_all !== '0 || en_total != base) begin bad++; $display("FAIL midrst_wloaded: err=%b h=%h en=%0d want 1/0/0", err, h_all, en_total - base); end
  endtask

  initial begin
    test_reset();
    test_weight();
    test_hidden_fire();
    test_stall_toggle();
    test_timeout();
    test_hidden_no_weight();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/gru_param_loader.md
GRU_PARAM_LOADER -- requirements
Module: gru_param_loader

Interface
REQ-001 Parameter: WORD_W, default 16, data word width; signed fixed point Q2.14, so 16'h4000 = 1.0.
REQ-002 Parameter: WAIT_MAX, default 255, maximum cycles spent in WAIT before the timeout fires.
REQ-003 Port: clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous assertion, active low.
REQ-005 Port: s_valid  input  1  upstream word valid.
REQ-006 Port: s_ready  output  1  loader accepts a word; a transfer occurs when s_valid and s_ready are both high.
REQ-007 Port: s_data  input  WORD_W  serial parameter word.
REQ-008 Port: s_sel  input  1  frame type: 1 = weight frame (8 words), 0 = hidden frame (4 words); sampled only on the first word of a frame.
REQ-009 Port: result_valid  input  1  completion pulse from the downstream output stage.
REQ-010 Port: w11..w14, w21..w24  output  WORD_W each  registered weight rows 1 and 2.
REQ-011 Port: h1..h4  output  WORD_W each  registered hidden-state vector.
REQ-012 Port: en  output  1  one-cycle start pulse to the downstream output stage.
REQ-013 Port: busy  output  1  high in every state other than IDLE.
REQ-014 Port: err  output  1  sticky error flag.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, FIRE, WAIT.
REQ-016 In IDLE and LOAD, s_ready SHALL be 1; in FIRE and WAIT, s_ready SHALL be 0.
REQ-017 On a transfer in IDLE, the FSM SHALL latch s_sel as frame type, store the word at index 0, and go to LOAD.
REQ-018 Each transfer SHALL store s_data into a staging register at a 4-bit index that increments by 1 per transfer.
REQ-019 Word order SHALL be w11,w12,w13,w14,w21,w22,w23,w24 for a weight frame and h1,h2,h3,h4 for a hidden frame.
REQ-020 Changes of s_sel after the first word of a frame SHALL be ignored.
REQ-021 Cycles without a transfer in LOAD SHALL leave state and index unchanged (stall, no timeout).
REQ-022 On the last transfer of a weight frame (index 7), all eight w outputs SHALL update together on that edge, w_loaded SHALL be set, and the FSM SHALL return to IDLE.
REQ-023 On the last transfer of a hidden frame (index 3) with w_loaded=1, h1..h4 SHALL update together on that edge and the FSM SHALL go to FIRE.
REQ-024 On the last transfer of a hidden frame with w_loaded=0, h outputs SHALL be left unchanged, err SHALL be set, and the FSM SHALL return to IDLE.
REQ-025 In FIRE, en SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-026 Latency SHALL be: en is high in the cycle after the edge that accepted the last hidden word.
REQ-027 The FSM SHALL leave WAIT for IDLE on the first cycle result_valid=1.
REQ-028 If WAIT lasts WAIT_MAX cycles without result_valid, err SHALL be set and the FSM SHALL go to IDLE.
REQ-029 result_valid outside WAIT SHALL be ignored.
REQ-030 Outputs w* and h* SHALL never change in FIRE or WAIT.
REQ-031 A partial frame SHALL never alter w* or h*.
REQ-032 The loader SHALL perform no arithmetic on data; words SHALL pass bit-exact.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state=IDLE, index=0, all w*, h* and staging registers=0, w_loaded=0, en=0, err=0, busy=0.
REQ-034 Reset asserted mid-frame or in WAIT SHALL discard the partial frame and clear w_loaded.
REQ-035 err SHALL be cleared only by reset.

Structure
REQ-036 A shared package SHALL hold the state enum, frame lengths (8 and 4), the Q2.14 ONE constant (16'h4000), and the index width.
REQ-037 The block SHALL be a single module with no sub-modules; the staging register file SHALL be inline.

Verification
REQ-038 Scenario: weight frame 16'h0001..16'h0008 with s_valid held high -> after 8 transfers w11=1 … w24=8, busy=0, en never asserted.
REQ-039 Scenario: the weight frame above, then hidden frame 16'h4000,16'hC000,16'h2000,16'h0000 -> h1..h4 hold those values, en=1 in the cycle after the 4th transfer, s_ready=0 until result_valid.
REQ-040 Scenario: hidden frame sent directly after reset -> err=1, en stays 0, h* stay 0.
REQ-041 Scenario: s_valid toggled every other cycle, s_sel flipped after word 0 -> frame type unchanged, values correct, index advances only on transfers.
REQ-042 Scenario: no result_valid after en -> err=1 and IDLE after WAIT_MAX (255) cycles; the next hidden frame is accepted.
REQ-043 Scenario: rst_n pulsed low after 5 weight words -> all outputs 0 and w_loaded=0; a following hidden frame sets err.
